// File: rtl/bitmap_offset_scan.sv
// Two-stage bitmap-to-offset scanner: per-lane code sizes, inclusive prefix
// ends, beat total and a running stream base with sticky wrap flag.
module bitmap_offset_scan #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned CODE_W    = 2,
  parameter int unsigned LEN_W     = 10,
  parameter int unsigned ACCUM_W   = 32,
  parameter int unsigned SIZE_0    = 0,
  parameter int unsigned SIZE_1    = 8,
  parameter int unsigned SIZE_2    = 16,
  parameter int unsigned SIZE_3    = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_LANES*CODE_W-1:0]   s_bitmap,
  input  logic                          s_last,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [NUM_LANES*LEN_W-1:0]    m_end,
  output logic [LEN_W-1:0]              m_total,
  output logic [ACCUM_W-1:0]            m_base,
  output logic                          m_last,
  output logic                          m_ovf,
  output logic                          m_valid,
  input  logic                          m_ready
);

  localparam int unsigned MAX01 = (SIZE_0 > SIZE_1) ? SIZE_0 : SIZE_1;
  localparam int unsigned MAX23 = (SIZE_2 > SIZE_3) ? SIZE_2 : SIZE_3;
  localparam int unsigned MAX_SZ = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int unsigned SW =
    ((ACCUM_W > LEN_W) ? ACCUM_W : LEN_W) + 1;

  if (longint'(NUM_LANES) * longint'(MAX_SZ)
      >= (longint'(1) << LEN_W)) begin : g_len_chk
    $error("LEN_W too narrow for worst-case beat total");
  end
  if (CODE_W < 2) begin : g_code_chk
    $error("CODE_W must be at least 2");
  end

  typedef logic [NUM_LANES-1:0][LEN_W-1:0] lanes_t;

  logic               s1_valid_q, s1_valid_d;
  lanes_t             s1_size_q, s1_size_d;
  logic               s1_last_q, s1_last_d;
  logic               m_valid_q, m_valid_d;
  lanes_t             m_end_q, m_end_d;
  logic [LEN_W-1:0]   m_total_q, m_total_d;
  logic [ACCUM_W-1:0] m_base_q, m_base_d;
  logic               m_last_q, m_last_d;
  logic               m_ovf_q, m_ovf_d;
  logic [ACCUM_W-1:0] base_acc_q, base_acc_d;
  logic               ovf_acc_q, ovf_acc_d;

  logic               s2_load;
  logic               s1_load;
  logic               s_fire;
  lanes_t             lut;
  lanes_t             ends;
  logic [LEN_W-1:0]   pre_acc;
  logic [SW-1:0]      sum;
  logic               carry;
  logic               ovf_now;

  assign s2_load = s1_valid_q & (~m_valid_q | m_ready);
  assign s1_load = ~s1_valid_q | s2_load;
  assign s_ready = s1_load;
  assign s_fire  = s_valid & s1_load;

  always_comb begin
    lut = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      case (s_bitmap[i*CODE_W +: 2])
        2'd0:    lut[i] = LEN_W'(SIZE_0);
        2'd1:    lut[i] = LEN_W'(SIZE_1);
        2'd2:    lut[i] = LEN_W'(SIZE_2);
        default: lut[i] = LEN_W'(SIZE_3);
      endcase
    end
  end

  // Serial prefix; width is bounded by the elaboration check above.
  always_comb begin
    pre_acc = '0;
    ends    = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      pre_acc = pre_acc + s1_size_q[i];
      ends[i] = pre_acc;
    end
  end

  assign sum     = SW'(base_acc_q) + SW'(pre_acc);
  assign carry   = |sum[SW-1:ACCUM_W];
  assign ovf_now = ovf_acc_q | (carry & ~s1_last_q);

  always_comb begin
    s1_valid_d = s1_load ? s_valid : s1_valid_q;
    s1_size_d  = s1_size_q;
    s1_last_d  = s1_last_q;
    m_valid_d  = s2_load | (m_valid_q & ~m_ready);
    m_end_d    = m_end_q;
    m_total_d  = m_total_q;
    m_base_d   = m_base_q;
    m_last_d   = m_last_q;
    m_ovf_d    = m_ovf_q;
    base_acc_d = base_acc_q;
    ovf_acc_d  = ovf_acc_q;
    if (s_fire) begin
      s1_size_d = lut;
      s1_last_d = s_last;
    end
    if (s2_load) begin
      m_end_d    = ends;
      m_total_d  = pre_acc;
      m_base_d   = base_acc_q;
      m_last_d   = s1_last_q;
      m_ovf_d    = ovf_now;
      base_acc_d = s1_last_q ? '0 : sum[ACCUM_W-1:0];
      ovf_acc_d  = s1_last_q ? 1'b0 : ovf_now;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q <= 1'b0;
      s1_size_q  <= '0;
      s1_last_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_end_q    <= '0;
      m_total_q  <= '0;
      m_base_q   <= '0;
      m_last_q   <= 1'b0;
      m_ovf_q    <= 1'b0;
      base_acc_q <= '0;
      ovf_acc_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_size_q  <= s1_size_d;
      s1_last_q  <= s1_last_d;
      m_valid_q  <= m_valid_d;
      m_end_q    <= m_end_d;
      m_total_q  <= m_total_d;
      m_base_q   <= m_base_d;
      m_last_q   <= m_last_d;
      m_ovf_q    <= m_ovf_d;
      base_acc_q <= base_acc_d;
      ovf_acc_q  <= ovf_acc_d;
    end
  end

  assign m_end   = m_end_q;
  assign m_total = m_total_q;
  assign m_base  = m_base_q;
  assign m_last  = m_last_q;
  assign m_ovf   = m_ovf_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_bitmap_offset_scan.sv
// Randomized and directed bench for bitmap_offset_scan against a
// lane-size/stream-offset reference model with an in-order scoreboard.
module tb_bitmap_offset_scan;

  logic        aclk;
  logic        aresetn;
  logic [15:0] s_bitmap;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [79:0] m_end;
  logic [9:0]  m_total;
  logic [31:0] m_base;
  logic        m_last;
  logic        m_ovf;
  logic        m_valid;
  logic        m_ready;

  logic [15:0] o_s_bitmap;
  logic        o_s_last;
  logic        o_s_valid;
  logic        o_s_ready;
  logic [79:0] o_m_end;
  logic [9:0]  o_m_total;
  logic [7:0]  o_m_base;
  logic        o_m_last;
  logic        o_m_ovf;
  logic        o_m_valid;
  logic        o_m_ready;

  bitmap_offset_scan dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_bitmap(s_bitmap), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_end(m_end), .m_total(m_total),
    .m_base(m_base), .m_last(m_last),
    .m_ovf(m_ovf), .m_valid(m_valid),
    .m_ready(m_ready)
  );

  bitmap_offset_scan #(.ACCUM_W(8)) dut_ovf (
    .aclk(aclk), .aresetn(aresetn),
    .s_bitmap(o_s_bitmap), .s_last(o_s_last),
    .s_valid(o_s_valid), .s_ready(o_s_ready),
    .m_end(o_m_end), .m_total(o_m_total),
    .m_base(o_m_base), .m_last(o_m_last),
    .m_ovf(o_m_ovf), .m_valid(o_m_valid),
    .m_ready(o_m_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [79:0] e;
    logic [9:0]  t;
    logic [31:0] b;
    logic        l;
  } exp_t;

  exp_t        q[$];
  longint      model_base;
  int          checks;
  int          failures;
  logic        last_acc;

  function automatic int lane_size(input int code);
    int tbl[4] = '{0, 8, 16, 32};
    return tbl[code];
  endfunction

  function automatic exp_t model(input logic [15:0] bm,
                                 input logic l);
    exp_t x;
    int   acc;
    acc = 0;
    x.e = '0;
    for (int i = 0; i < 8; i++) begin
      acc += lane_size(int'((bm >> (2 * i)) & 16'h3));
      x.e[i*10 +: 10] = 10'(acc);
    end
    x.t = 10'(acc);
    x.b = 32'(model_base);
    x.l = l;
    model_base = l ? 0 : model_base + acc;
    return x;
  endfunction

  task automatic step(input logic v, input logic [15:0] bm,
                      input logic l, input logic r);
    exp_t x;
    @(negedge aclk);
    s_valid  = v;
    s_bitmap = bm;
    s_last   = l;
    m_ready  = r;
    #1;
    last_acc = 1'b0;
    if (m_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat: m_valid=1 but none pending");
      end else begin
        x = q[0];
        if (m_end !== x.e || m_total !== x.t || m_base !== x.b ||
            m_last !== x.l || m_ovf !== 1'b0) begin
          failures++;
          $display("FAIL beat: end=%h want %h total=%0d want %0d base=%0d want %0d last=%b want %b ovf=%b want 0",
                   m_end, x.e, m_total, x.t, m_base, x.b,
                   m_last, x.l, m_ovf);
        end
        if (r) void'(q.pop_front());
      end
    end
    if (v && s_ready) begin
      q.push_back(model(bm, l));
      last_acc = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || m_valid) && n < 40) begin
      step(1'b0, 16'h0, 1'b0, 1'b1);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d want 0", q.size());
    end
  endtask

  task automatic test_reset();
    aresetn    = 1'b0;
    s_valid    = 1'b0;
    s_bitmap   = '0;
    s_last     = 1'b0;
    m_ready    = 1'b1;
    o_s_valid  = 1'b0;
    o_s_bitmap = '0;
    o_s_last   = 1'b0;
    o_m_ready  = 1'b1;
    model_base = 0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_end !== '0 || m_total !== '0 ||
        m_base !== '0 || m_last !== 1'b0 || m_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b end=%h total=%0d base=%0d last=%b ovf=%b want all 0",
               m_valid, m_end, m_total, m_base, m_last, m_ovf);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_s_ready: got %b want 1", s_ready);
    end
  endtask

  task automatic test_latency();
    step(1'b1, 16'h0000, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: m_valid=%b want 0 after 1 cycle",
               m_valid);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    checks++;
    if (m_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_2cyc: m_valid=%b want 1 after 2 cycles",
               m_valid);
    end
    drain();
  endtask

  task automatic test_patterns();
    step(1'b1, 16'hFFFF, 1'b1, 1'b1);
    step(1'b1, 16'h00E4, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_stream();
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, 16'h00E4, 1'b1, 1'b1);
    step(1'b1, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] bms[4];
    int          idx;
    int          run;
    bms = '{16'h1234, 16'hABCD, 16'h5555, 16'hE4E4};
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, bms[idx], 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    checks++;
    if (idx != 2 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_accept: accepted=%0d s_ready=%b want 2 and 0",
               idx, s_ready);
    end
    run = 0;
    for (int c = 0; c < 4; c++) begin
      if (idx < 4) begin
        step(1'b1, bms[idx], 1'b0, 1'b1);
        if (last_acc) idx++;
      end else begin
        step(1'b0, 16'h0, 1'b0, 1'b1);
      end
      if (m_valid) run++;
    end
    checks++;
    if (run != 4 || idx != 4) begin
      failures++;
      $display("FAIL resume_rate: beats=%0d accepted=%0d want 4 and 4",
               run, idx);
    end
    step(1'b1, 16'h0000, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 3) != 0, 16'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
    end
    drain();
  endtask

  task automatic test_ovf();
    logic [15:0] obm[5];
    logic        ol[5];
    logic [7:0]  rb[5];
    logic        ro[5];
    logic        rl[5];
    logic [9:0]  rt[5];
    int          n;
    obm = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 16'h0001};
    ol  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rb[i] = '0; ro[i] = 1'b0; rl[i] = 1'b0; rt[i] = '0;
    end
    n = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge aclk);
      o_m_ready = 1'b1;
      if (c < 5) begin
        o_s_valid  = 1'b1;
        o_s_bitmap = obm[c];
        o_s_last   = ol[c];
      end else begin
        o_s_valid  = 1'b0;
        o_s_bitmap = '0;
        o_s_last   = 1'b0;
      end
      #1;
      if (o_m_valid && n < 5) begin
        rb[n] = o_m_base;
        ro[n] = o_m_ovf;
        rl[n] = o_m_last;
        rt[n] = o_m_total;
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL ovf_count: beats=%0d want 5", n);
    end
    checks++;
    if (rb[0] !== 8'd0 || rt[0] !== 10'd256) begin
      failures++;
      $display("FAIL ovf_b0: base=%0d total=%0d want 0 256",
               rb[0], rt[0]);
    end
    checks++;
    if (rb[1] !== 8'd0 || ro[1] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_wrap: base=%0d ovf=%b want 0 1", rb[1], ro[1]);
    end
    checks++;
    if (rb[2] !== 8'd0 || ro[2] !== 1'b1 || rt[2] !== 10'd8) begin
      failures++;
      $display("FAIL ovf_sticky: base=%0d ovf=%b total=%0d want 0 1 8",
               rb[2], ro[2], rt[2]);
    end
    checks++;
    if (rb[3] !== 8'd8 || ro[3] !== 1'b1 || rl[3] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_last: base=%0d ovf=%b last=%b want 8 1 1",
               rb[3], ro[3], rl[3]);
    end
    checks++;
    if (rb[4] !== 8'd0 || ro[4] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: base=%0d ovf=%b want 0 0", rb[4], ro[4]);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b1, 16'hAAAA, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_full: m_valid=%b s_ready=%b want 1 0",
               m_valid, s_ready);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_async: m_valid=%b s_ready=%b want 0 1",
               m_valid, s_ready);
    end
    q.delete();
    model_base = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    step(1'b1, 16'h0055, 1'b0, 1'b1);
    step(1'b1, 16'h0003, 1'b1, 1'b1);
    drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    last_acc = 1'b0;
    test_reset();
    test_latency();
    test_patterns();
    test_stream();
    test_back_to_back();
    test_random();
    test_ovf();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
